// File: rtl/vga_timing_gen.sv
// Purpose : parametrised raster timing generator (sync, active area, pixel coords, strobes, frame count).
// Latency : outputs reflect the counter position PIPE_DELAY ce-qualified edges earlier.
// Backpress: none; ce=0 freezes counters, pipeline and frame count in place.
//
// Ports:
//   clk, reset    pixel clock, synchronous active-high reset (wins over ce)
//   ce            pixel enable
//   hsync, vsync  syncs driven at HSYNC_POL / VSYNC_POL when asserted
//   activevideo   high inside the visible area
//   x_px, y_px    visible column/row, 0 outside the visible area
//   line_start    one-pixel strobe at hc==0
//   endframe      one-pixel strobe on the last pixel of the frame
//   frame_cnt     completed-frame count, wraps modulo 2^FRAME_W
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 128,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 9,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 28,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 1,
  parameter int CW         = 10,
  parameter int FRAME_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  output logic               hsync,
  output logic               vsync,
  output logic               activevideo,
  output logic [CW-1:0]      x_px,
  output logic [CW-1:0]      y_px,
  output logic               line_start,
  output logic               endframe,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_BLANK = H_FP + H_SYNC + H_BP;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_BLANK = V_FP + V_SYNC + V_BP;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_LO = CW'(H_FP);
  localparam logic [CW-1:0] H_SYNC_HI = CW'(H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_LO = CW'(V_FP);
  localparam logic [CW-1:0] V_SYNC_HI = CW'(V_FP + V_SYNC);
  localparam logic [CW-1:0] H_BLANK_W = CW'(H_BLANK);
  localparam logic [CW-1:0] V_BLANK_W = CW'(V_BLANK);

  if (PIPE_DELAY < 1) begin : g_err_pipe
    $error("vga_timing_gen: PIPE_DELAY must be at least 1");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_len
    $error("vga_timing_gen: all timing lengths must be non-zero");
  end
  if (longint'(H_TOTAL) > (64'd1 << CW) || longint'(V_TOTAL) > (64'd1 << CW)) begin : g_err_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL-1 / V_TOTAL-1");
  end

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          active;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          endframe;
  } stage_t;

  // Value every pipeline stage holds after reset until real data reaches it.
  localparam stage_t IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, active: 1'b0,
                              x: '0, y: '0, line_start: 1'b0, endframe: 1'b0};

  logic [CW-1:0]      hc_q, hc_d;
  logic [CW-1:0]      vc_q, vc_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  stage_t             raw;
  stage_t             pipe_q [PIPE_DELAY];
  stage_t             pipe_d [PIPE_DELAY];

  // Raster counters
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (ce) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
      end else begin
        hc_d = hc_q + CW'(1);
      end
    end
  end

  // Raw per-position signals, decoded from the current counter values
  always_comb begin
    logic h_act, v_act;
    h_act          = (hc_q >= H_BLANK_W);
    v_act          = (vc_q >= V_BLANK_W);
    raw            = IDLE;
    raw.hsync      = (hc_q >= H_SYNC_LO && hc_q < H_SYNC_HI) ? HSYNC_POL : ~HSYNC_POL;
    raw.vsync      = (vc_q >= V_SYNC_LO && vc_q < V_SYNC_HI) ? VSYNC_POL : ~VSYNC_POL;
    raw.active     = h_act && v_act;
    raw.x          = (h_act && v_act) ? hc_q - H_BLANK_W : '0;
    raw.y          = (h_act && v_act) ? vc_q - V_BLANK_W : '0;
    raw.line_start = (hc_q == '0);
    raw.endframe   = (hc_q == H_LAST) && (vc_q == V_LAST);
  end

  // Alignment pipeline; shifts only on ce so strobes hold across ce=0 edges
  always_comb begin
    for (int i = 0; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i];
    if (ce) begin
      pipe_d[0] = raw;
      for (int i = 1; i < PIPE_DELAY; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  // The endframe output rises exactly when a ce edge loads it into the last stage.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (ce && pipe_d[PIPE_DELAY-1].endframe) frame_cnt_d = frame_cnt_q + FRAME_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hc_q        <= '0;
      vc_q        <= '0;
      frame_cnt_q <= '0;
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= IDLE;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      frame_cnt_q <= frame_cnt_d;
      for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign hsync       = pipe_q[PIPE_DELAY-1].hsync;
  assign vsync       = pipe_q[PIPE_DELAY-1].vsync;
  assign activevideo = pipe_q[PIPE_DELAY-1].active;
  assign x_px        = pipe_q[PIPE_DELAY-1].x;
  assign y_px        = pipe_q[PIPE_DELAY-1].y;
  assign line_start  = pipe_q[PIPE_DELAY-1].line_start;
  assign endframe    = pipe_q[PIPE_DELAY-1].endframe;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Purpose : bench for vga_timing_gen; two instances (PIPE_DELAY=1/FRAME_W=8 and PIPE_DELAY=3/HSYNC_POL=1/FRAME_W=2).
// Latency : expected outputs derive from the ce-edge count since reset via a closed-form raster model.
// Backpress: none; ce is randomised, including a long ce=0 hold.
module tb_vga_timing_gen;

  localparam int HFP = 1, HSW = 2, HBP = 1, HACT = 8;
  localparam int VFP = 1, VSW = 1, VBP = 1, VACT = 4;
  localparam int HB = HFP + HSW + HBP, HT = HB + HACT;
  localparam int VB = VFP + VSW + VBP, VT = VB + VACT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;

  logic       hs_a, vs_a, av_a, ls_a, ef_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;
  logic       hs_b, vs_b, av_b, ls_b, ef_b;
  logic [9:0] x_b, y_b;
  logic [1:0] fc_b;

  int n_chk = 0;
  int n_pass = 0;
  int n_ce = 0;      // ce-qualified edges since reset release
  int n_clk = 0;     // all edges since reset release
  bit all_ce = 1'b0; // every edge since release had ce=1
  bit tog = 1'b0;    // ce-toggling scenario active

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HACT), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VACT), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(1), .CW(10), .FRAME_W(8)
  ) dut_a (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hs_a), .vsync(vs_a), .activevideo(av_a), .x_px(x_a), .y_px(y_a),
    .line_start(ls_a), .endframe(ef_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HACT), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VACT), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE_DELAY(3), .CW(10), .FRAME_W(2)
  ) dut_b (
    .clk(clk), .reset(reset), .ce(ce),
    .hsync(hs_b), .vsync(vs_b), .activevideo(av_b), .x_px(x_b), .y_px(y_b),
    .line_start(ls_b), .endframe(ef_b), .frame_cnt(fc_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (clk %0d, ce-edge %0d)", tag, obs, exp, n_clk, n_ce);
  endtask

  // Closed-form raster model: what an instance with delay d shows after ce-edge n.
  typedef struct {
    bit hs, vs, av, ls, ef;
    int x, y, fc;
  } exp_t;

  function automatic exp_t model(input int d, input int n, input bit hpol, input bit vpol, input int fw);
    exp_t e;
    int idx, hc, vc;
    idx = n - d;
    e.hs = ~hpol; e.vs = ~vpol; e.av = 0; e.ls = 0; e.ef = 0;
    e.x = 0; e.y = 0; e.fc = 0;
    if (idx >= 0) begin
      hc   = idx % HT;
      vc   = (idx / HT) % VT;
      e.hs = (hc >= HFP && hc < HFP + HSW) ? hpol : ~hpol;
      e.vs = (vc >= VFP && vc < VFP + VSW) ? vpol : ~vpol;
      e.av = (hc >= HB) && (vc >= VB);
      e.x  = e.av ? hc - HB : 0;
      e.y  = e.av ? vc - VB : 0;
      e.ls = (hc == 0);
      e.ef = (hc == HT - 1) && (vc == VT - 1);
      e.fc = ((idx + 1) / (HT * VT)) % (1 << fw);
    end
    return e;
  endfunction

  task automatic check_model();
    exp_t ea, eb;
    ea = model(1, n_ce, 1'b0, 1'b0, 8);
    eb = model(3, n_ce, 1'b1, 1'b0, 2);
    chk("a.hsync", hs_a, ea.hs);  chk("a.vsync", vs_a, ea.vs);
    chk("a.active", av_a, ea.av); chk("a.x", x_a, ea.x);
    chk("a.y", y_a, ea.y);        chk("a.line_start", ls_a, ea.ls);
    chk("a.endframe", ef_a, ea.ef); chk("a.frame_cnt", fc_a, ea.fc);
    chk("b.hsync", hs_b, eb.hs);  chk("b.vsync", vs_b, eb.vs);
    chk("b.active", av_b, eb.av); chk("b.x", x_b, eb.x);
    chk("b.y", y_b, eb.y);        chk("b.line_start", ls_b, eb.ls);
    chk("b.endframe", ef_b, eb.ef); chk("b.frame_cnt", fc_b, eb.fc);
  endtask

  // Hand-derived timing points along the raster
  task automatic check_directed(input bit r);
    if (r) begin
      chk("rst.a_active", av_a, 0); chk("rst.a_frame_cnt", fc_a, 0);
      chk("rst.a_hsync", hs_a, 1);  chk("rst.b_hsync", hs_b, 0);
    end else if (all_ce) begin
      case (n_ce)
        1:   begin chk("d.hs_e1", hs_a, 1); chk("d.ls_e1", ls_a, 1); end
        2:   begin chk("d.hs_e2", hs_a, 0); chk("d.b_hs_e2", hs_b, 0); chk("d.b_av_e2", av_b, 0); end
        3:   chk("d.hs_e3", hs_a, 0);
        4:   begin chk("d.hs_e4", hs_a, 1); chk("d.b_hs_e4", hs_b, 1); end
        5:   chk("d.b_hs_e5", hs_b, 1);
        12:  chk("d.vs_e12", vs_a, 1);
        13:  begin chk("d.ls_e13", ls_a, 1); chk("d.vs_e13", vs_a, 0); end
        24:  chk("d.vs_e24", vs_a, 0);
        25:  begin chk("d.ls_e25", ls_a, 1); chk("d.vs_e25", vs_a, 1); end
        40:  chk("d.av_e40", av_a, 0);
        41:  begin chk("d.av_e41", av_a, 1); chk("d.x_e41", x_a, 0); chk("d.y_e41", y_a, 0); end
        42:  chk("d.b_av_e42", av_b, 0);
        43:  chk("d.b_av_e43", av_b, 1);
        48:  begin chk("d.x_e48", x_a, 7); chk("d.y_e48", y_a, 0); end
        49:  begin chk("d.av_e49", av_a, 0); chk("d.x_e49", x_a, 0); end
        84:  begin chk("d.ef_e84", ef_a, 1); chk("d.x_e84", x_a, 7); chk("d.y_e84", y_a, 3); chk("d.fc_e84", fc_a, 1); end
        85:  chk("d.ef_e85", ef_a, 0);
        168: begin chk("d.ef_e168", ef_a, 1); chk("d.fc_e168", fc_a, 2); end
        252: begin chk("d.ef_e252", ef_a, 1); chk("d.fc_e252", fc_a, 3); end
        338: begin chk("d.b_ef_f4", ef_b, 1); chk("d.b_fc_f4", fc_b, 0); end
        default: ;
      endcase
    end else if (tog) begin
      case (n_clk)
        165: chk("t.ef_e165", ef_a, 0);
        167: begin chk("t.ef_e167", ef_a, 1); chk("t.fc_e167", fc_a, 1); end
        168: chk("t.ef_hold_e168", ef_a, 1);
        169: chk("t.ef_e169", ef_a, 0);
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit r, input bit c);
    reset = r;
    ce    = c;
    @(posedge clk);
    #1;
    if (r) begin
      n_ce = 0; n_clk = 0; all_ce = 1'b1;
    end else begin
      n_clk++;
      if (c) n_ce++;
      else all_ce = 1'b0;
    end
    check_model();
    check_directed(r);
  endtask

  initial begin
    // Reset 3 clocks, then 4+ frames with ce=1
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 340; i++) step(1'b0, 1'b1);

    // Mid-active reset, then replay from the start
    step(1'b1, 1'b1);
    for (int i = 0; i < 59; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 90; i++) step(1'b0, 1'b1);

    // ce toggling 1,0,1,0 from reset release
    step(1'b1, 1'b0);
    tog = 1'b1;
    for (int i = 0; i < 172; i++) step(1'b0, (i % 2) == 0);
    tog = 1'b0;

    // Random ce with occasional resets and one long ce=0 hold mid-line
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        step(1'b1, 1'b1);
        for (int k = 0; k < 30; k++) step(1'b0, 1'b1);
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 1'b1);
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
